dag_dm_addr: RTL and testbench

- Data address generator directly upstream of the memory block's DM port; produces the registered dg_dm_add.
- Holds 4 index (I), modify (M), length (L) and base (B) registers.
- Performs pre-modify or post-modify addressing with optional circular-buffer wrap.
- Registers are loaded and read over the ureg path shared with the bus connect (bc_*).

---
 rtl/dag_pkg.sv | 19 +
 rtl/dag_circ_add.sv | 35 +++
 rtl/dag_dm_addr.sv | 124 ++++++++++++
 tb/tb_dag_dm_addr.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dag_pkg.sv
// Shared encodings for the data address generator.
package dag_pkg;

  localparam int unsigned DG_NREG = 4;

  // ureg select field positions: [3:2] register class, [1:0] register index.
  localparam int unsigned DG_UREG_CLS_MSB = 3;
  localparam int unsigned DG_UREG_CLS_LSB = 2;
  localparam int unsigned DG_UREG_IDX_MSB = 1;
  localparam int unsigned DG_UREG_IDX_LSB = 0;

  typedef enum logic [1:0] {
    DG_CLS_I = 2'b00,
    DG_CLS_M = 2'b01,
    DG_CLS_L = 2'b10,
    DG_CLS_B = 2'b11
  } dg_cls_e;

endpackage

// File: rtl/dag_circ_add.sv
// Index update arithmetic: I+M with optional circular-buffer wrap into [B, B+L).
module dag_circ_add #(
  parameter int unsigned DMA_SIZE = 16
) (
  input  logic [DMA_SIZE-1:0] i_i,
  input  logic [DMA_SIZE-1:0] m_i,
  input  logic [DMA_SIZE-1:0] l_i,
  input  logic [DMA_SIZE-1:0] b_i,
  output logic [DMA_SIZE-1:0] w_o
);

  // Two guard bits: one for the unsigned carry, one for the sign of M.
  localparam int unsigned SW = DMA_SIZE + 2;

  logic signed [SW-1:0] sum;
  logic signed [SW-1:0] lo;
  logic signed [SW-1:0] hi;

  assign sum = $signed({2'b00, i_i}) + $signed({{2{m_i[DMA_SIZE-1]}}, m_i});
  assign lo  = $signed({2'b00, b_i});
  assign hi  = $signed({2'b00, b_i}) + $signed({2'b00, l_i});

  // L=0 means linear addressing; otherwise fold one buffer length back into range.
  always_comb begin
    w_o = sum[DMA_SIZE-1:0];
    if (l_i != '0) begin
      if (sum >= hi) begin
        w_o = sum[DMA_SIZE-1:0] - l_i;
      end else if (sum < lo) begin
        w_o = sum[DMA_SIZE-1:0] + l_i;
      end
    end
  end

endmodule

// File: rtl/dag_dm_addr.sv
// DM data address generator: I/M/L/B register files, ureg access, registered DM address.
module dag_dm_addr
  import dag_pkg::*;
#(
  parameter int unsigned DMA_SIZE = 16,
  parameter int unsigned NREG     = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ps_dg_en,
  input  logic                ps_dg_pre,
  input  logic [1:0]          ps_dg_iadd,
  input  logic [1:0]          ps_dg_madd,
  input  logic                ps_dg_wrt_en,
  input  logic                ps_dg_rd_en,
  input  logic [3:0]          ps_dg_ureg_add,
  input  logic [DMA_SIZE-1:0] bc_dg_dt,
  output logic [DMA_SIZE-1:0] dg_dm_add,
  output logic [DMA_SIZE-1:0] dg_bc_dt
);

  logic [DMA_SIZE-1:0] i_q [NREG];
  logic [DMA_SIZE-1:0] i_d [NREG];
  logic [DMA_SIZE-1:0] m_q [NREG];
  logic [DMA_SIZE-1:0] m_d [NREG];
  logic [DMA_SIZE-1:0] l_q [NREG];
  logic [DMA_SIZE-1:0] l_d [NREG];
  logic [DMA_SIZE-1:0] b_q [NREG];
  logic [DMA_SIZE-1:0] b_d [NREG];
  logic [DMA_SIZE-1:0] add_q, add_d;
  logic [DMA_SIZE-1:0] bc_q, bc_d;

  dg_cls_e             ureg_cls;
  logic [1:0]          ureg_idx;
  logic [DMA_SIZE-1:0] rd_val;
  logic [DMA_SIZE-1:0] wrap_val;

  assign ureg_cls = dg_cls_e'(ps_dg_ureg_add[DG_UREG_CLS_MSB:DG_UREG_CLS_LSB]);
  assign ureg_idx = ps_dg_ureg_add[DG_UREG_IDX_MSB:DG_UREG_IDX_LSB];

  // L and B follow the I selector; M has its own selector.
  dag_circ_add #(
    .DMA_SIZE(DMA_SIZE)
  ) u_circ_add (
    .i_i(i_q[ps_dg_iadd]),
    .m_i(m_q[ps_dg_madd]),
    .l_i(l_q[ps_dg_iadd]),
    .b_i(b_q[ps_dg_iadd]),
    .w_o(wrap_val)
  );

  // ureg read mux over pre-edge register contents.
  always_comb begin
    rd_val = '0;
    unique case (ureg_cls)
      DG_CLS_I: rd_val = i_q[ureg_idx];
      DG_CLS_M: rd_val = m_q[ureg_idx];
      DG_CLS_L: rd_val = l_q[ureg_idx];
      DG_CLS_B: rd_val = b_q[ureg_idx];
      default:  rd_val = '0;
    endcase
  end

  // Next state: access update first, then ureg write so it wins on the same I register.
  always_comb begin
    i_d   = i_q;
    m_d   = m_q;
    l_d   = l_q;
    b_d   = b_q;
    add_d = add_q;
    bc_d  = bc_q;

    if (ps_dg_en) begin
      if (ps_dg_pre) begin
        add_d = wrap_val;
      end else begin
        add_d              = i_q[ps_dg_iadd];
        i_d[ps_dg_iadd]    = wrap_val;
      end
    end

    if (ps_dg_wrt_en) begin
      unique case (ureg_cls)
        DG_CLS_I: i_d[ureg_idx] = bc_dg_dt;
        DG_CLS_M: m_d[ureg_idx] = bc_dg_dt;
        DG_CLS_L: l_d[ureg_idx] = bc_dg_dt;
        DG_CLS_B: begin
          b_d[ureg_idx] = bc_dg_dt;
          i_d[ureg_idx] = bc_dg_dt;
        end
        default: ;
      endcase
    end

    if (ps_dg_rd_en) begin
      bc_d = rd_val;
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NREG; k++) begin
        i_q[k] <= '0;
        m_q[k] <= '0;
        l_q[k] <= '0;
        b_q[k] <= '0;
      end
      add_q <= '0;
      bc_q  <= '0;
    end else begin
      i_q   <= i_d;
      m_q   <= m_d;
      l_q   <= l_d;
      b_q   <= b_d;
      add_q <= add_d;
      bc_q  <= bc_d;
    end
  end

  assign dg_dm_add = add_q;
  assign dg_bc_dt  = bc_q;

endmodule

// File: tb/tb_dag_dm_addr.sv
// Self-checking bench for dag_dm_addr: directed cases plus random traffic vs. a behavioural model.
module tb_dag_dm_addr;

  logic        clk;
  logic        reset;
  logic        ps_dg_en;
  logic        ps_dg_pre;
  logic [1:0]  ps_dg_iadd;
  logic [1:0]  ps_dg_madd;
  logic        ps_dg_wrt_en;
  logic        ps_dg_rd_en;
  logic [3:0]  ps_dg_ureg_add;
  logic [15:0] bc_dg_dt;
  logic [15:0] dg_dm_add;
  logic [15:0] dg_bc_dt;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 0;

  dag_dm_addr #(
    .DMA_SIZE(16),
    .NREG(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ps_dg_en(ps_dg_en),
    .ps_dg_pre(ps_dg_pre),
    .ps_dg_iadd(ps_dg_iadd),
    .ps_dg_madd(ps_dg_madd),
    .ps_dg_wrt_en(ps_dg_wrt_en),
    .ps_dg_rd_en(ps_dg_rd_en),
    .ps_dg_ureg_add(ps_dg_ureg_add),
    .bc_dg_dt(bc_dg_dt),
    .dg_dm_add(dg_dm_add),
    .dg_bc_dt(dg_bc_dt)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: plain integer arithmetic on the wrap rule.
  function automatic logic [15:0] wrap(input logic [15:0] i, input logic [15:0] m,
                                       input logic [15:0] l, input logic [15:0] b);
    int s;
    s = int'(i) + int'($signed(m));
    if (l != 0) begin
      if (s >= int'(b) + int'(l)) s = s - int'(l);
      else if (s < int'(b)) s = s + int'(l);
    end
    return s[15:0];
  endfunction

  logic [15:0] mi [4];
  logic [15:0] mm [4];
  logic [15:0] ml [4];
  logic [15:0] mb [4];
  logic [15:0] e_add;
  logic [15:0] e_dt;

  // Model state update from the inputs seen at each rising edge.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 4; k++) begin
        mi[k] <= 16'h0;
        mm[k] <= 16'h0;
        ml[k] <= 16'h0;
        mb[k] <= 16'h0;
      end
      e_add <= 16'h0;
      e_dt  <= 16'h0;
    end else begin
      logic [15:0] w;
      logic [15:0] rv;
      int ix;
      w  = wrap(mi[ps_dg_iadd], mm[ps_dg_madd], ml[ps_dg_iadd], mb[ps_dg_iadd]);
      ix = int'(ps_dg_ureg_add[1:0]);
      case (ps_dg_ureg_add[3:2])
        2'd0:    rv = mi[ix];
        2'd1:    rv = mm[ix];
        2'd2:    rv = ml[ix];
        default: rv = mb[ix];
      endcase
      if (ps_dg_en) begin
        if (ps_dg_pre) e_add <= w;
        else begin
          e_add          <= mi[ps_dg_iadd];
          mi[ps_dg_iadd] <= w;
        end
      end
      if (ps_dg_wrt_en) begin
        case (ps_dg_ureg_add[3:2])
          2'd0: mi[ix] <= bc_dg_dt;
          2'd1: mm[ix] <= bc_dg_dt;
          2'd2: ml[ix] <= bc_dg_dt;
          default: begin
            mb[ix] <= bc_dg_dt;
            mi[ix] <= bc_dg_dt;
          end
        endcase
      end
      if (ps_dg_rd_en) e_dt <= rv;
    end
  end

  // Compare process: outputs against the model every falling edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("dm_add_model", dg_dm_add, e_add);
      chk("bc_dt_model", dg_bc_dt, e_dt);
    end
  end

  task automatic clr();
    ps_dg_en = 0; ps_dg_pre = 0; ps_dg_iadd = 0; ps_dg_madd = 0;
    ps_dg_wrt_en = 0; ps_dg_rd_en = 0; ps_dg_ureg_add = 0; bc_dg_dt = 0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
    clr();
  endtask

  task automatic uw(input logic [1:0] cls, input logic [1:0] idx, input logic [15:0] d);
    ps_dg_wrt_en = 1; ps_dg_ureg_add = {cls, idx}; bc_dg_dt = d;
    step();
  endtask

  task automatic ur(input logic [1:0] cls, input logic [1:0] idx);
    ps_dg_rd_en = 1; ps_dg_ureg_add = {cls, idx};
    step();
  endtask

  task automatic rq(input logic pre, input logic [1:0] i, input logic [1:0] m);
    ps_dg_en = 1; ps_dg_pre = pre; ps_dg_iadd = i; ps_dg_madd = m;
    step();
  endtask

  initial begin
    clr();
    reset = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1;
    cmp_en = 1;

    // Pin the model's wrap rule with hand-computed values.
    chk("model_lin", wrap(16'hFFFF, 16'h0001, 16'h0, 16'h0), 16'h0000);
    chk("model_circ_hi", wrap(16'h0104, 16'h0002, 16'h5, 16'h0100), 16'h0101);
    chk("model_circ_lo", wrap(16'h0100, 16'hFFFE, 16'h5, 16'h0100), 16'h0103);

    // Reset state: every register reads zero.
    for (int c = 0; c < 4; c++) begin
      for (int n = 0; n < 4; n++) begin
        ur(c[1:0], n[1:0]);
        chk("reset_rd", dg_bc_dt, 16'h0);
      end
    end
    chk("reset_add", dg_dm_add, 16'h0);

    // Linear post-modify.
    uw(2'd0, 2'd0, 16'h0010);
    uw(2'd1, 2'd0, 16'h0003);
    uw(2'd2, 2'd0, 16'h0000);
    rq(0, 2'd0, 2'd0); chk("lin_a0", dg_dm_add, 16'h0010);
    rq(0, 2'd0, 2'd0); chk("lin_a1", dg_dm_add, 16'h0013);
    rq(0, 2'd0, 2'd0); chk("lin_a2", dg_dm_add, 16'h0016);
    ur(2'd0, 2'd0);    chk("lin_i0", dg_bc_dt, 16'h0019);
    chk("lin_hold", dg_dm_add, 16'h0016);

    // Circular post-modify, B write also loads I.
    uw(2'd2, 2'd1, 16'h0005);
    uw(2'd1, 2'd1, 16'h0002);
    uw(2'd3, 2'd1, 16'h0100);
    ur(2'd0, 2'd1);    chk("circ_iload", dg_bc_dt, 16'h0100);
    rq(0, 2'd1, 2'd1); chk("circ_a0", dg_dm_add, 16'h0100);
    rq(0, 2'd1, 2'd1); chk("circ_a1", dg_dm_add, 16'h0102);
    rq(0, 2'd1, 2'd1); chk("circ_a2", dg_dm_add, 16'h0104);
    rq(0, 2'd1, 2'd1); chk("circ_a3", dg_dm_add, 16'h0101);
    uw(2'd1, 2'd1, 16'hFFFE);
    uw(2'd0, 2'd1, 16'h0100);
    rq(0, 2'd1, 2'd1); chk("circ_neg_a", dg_dm_add, 16'h0100);
    ur(2'd0, 2'd1);    chk("circ_neg_i", dg_bc_dt, 16'h0103);

    // Pre-modify.
    uw(2'd0, 2'd2, 16'h0020);
    uw(2'd1, 2'd2, 16'hFFFF);
    rq(1, 2'd2, 2'd2); chk("pre_a", dg_dm_add, 16'h001F);
    ur(2'd0, 2'd2);    chk("pre_i", dg_bc_dt, 16'h0020);
    uw(2'd0, 2'd3, 16'hFFFF);
    uw(2'd1, 2'd3, 16'h0001);
    rq(1, 2'd3, 2'd3); chk("pre_wrap", dg_dm_add, 16'h0000);

    // Collision: post-modify, ureg write and read of I0 in one cycle.
    uw(2'd0, 2'd0, 16'h0010);
    uw(2'd1, 2'd0, 16'h0001);
    ps_dg_en = 1; ps_dg_pre = 0; ps_dg_iadd = 0; ps_dg_madd = 0;
    ps_dg_wrt_en = 1; ps_dg_rd_en = 1; ps_dg_ureg_add = 4'b0000; bc_dg_dt = 16'h0050;
    step();
    chk("coll_add", dg_dm_add, 16'h0010);
    chk("coll_rd", dg_bc_dt, 16'h0010);
    ur(2'd0, 2'd0);    chk("coll_i0", dg_bc_dt, 16'h0050);

    // Async reset pulse between edges.
    rq(0, 2'd0, 2'd0);
    @(posedge clk);
    #2 reset = 0;
    #1;
    chk("areset_add", dg_dm_add, 16'h0);
    chk("areset_dt", dg_bc_dt, 16'h0);
    #1 reset = 1;
    @(negedge clk);
    #1;
    rq(0, 2'd0, 2'd0); chk("areset_req", dg_dm_add, 16'h0000);

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      ps_dg_en       = 1'($urandom % 2);
      ps_dg_pre      = 1'($urandom % 2);
      ps_dg_iadd     = 2'($urandom % 4);
      ps_dg_madd     = 2'($urandom % 4);
      ps_dg_wrt_en   = ($urandom % 3) == 0;
      ps_dg_rd_en    = 1'($urandom % 2);
      ps_dg_ureg_add = 4'($urandom % 16);
      if ($urandom % 2 == 1) bc_dg_dt = 16'($urandom_range(0, 15));
      else if ($urandom % 2 == 1) bc_dg_dt = 16'hFFF0 | 16'($urandom_range(0, 15));
      else bc_dg_dt = 16'($urandom);
      step();
    end

    cmp_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
